// File: rtl/pmvx_lut_pkg.sv
// pmvx_lut_pkg: shared defaults and helpers for the pmvx LUT interpolator.
//   Default index width, fraction width and output width.
//   round_const(frac_w): half-LSB constant added before the fraction shift
//   so the interpolated term is rounded to nearest.
package pmvx_lut_pkg;

  localparam int unsigned DefIdxW  = 5;
  localparam int unsigned DefFracW = 4;
  localparam int unsigned DefOw    = 15;

  function automatic int unsigned round_const(input int unsigned frac_w);
    return 32'd1 << (frac_w - 1);
  endfunction

endpackage

// File: rtl/pmvx_lut_table.sv
// pmvx_lut_table: register-array lookup table, one write port, two
// combinational read ports. All entries clear on asynchronous reset.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   wr_en, wr_addr, wr_data write strobe, address and data
//   rd_addr_a, rd_data_a   read port A (combinational)
//   rd_addr_b, rd_data_b   read port B (combinational)
module pmvx_lut_table
  import pmvx_lut_pkg::*;
#(
  parameter int unsigned IDX_W = DefIdxW,
  parameter int unsigned OW    = DefOw
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [OW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_addr_a,
  output logic [OW-1:0]    rd_data_a,
  input  logic [IDX_W-1:0] rd_addr_b,
  output logic [OW-1:0]    rd_data_b
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [OW-1:0] mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Depth; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/pmvx_lut_interp.sv
// pmvx_lut_interp: 3-stage pipelined table lookup with optional linear
// interpolation between neighbouring entries.
// Build option: define PMVX_LUT_INTERP_EN to interpolate; without it the
// output is the plain entry T[i] with identical latency and handshake.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   in_valid, in_ready, x      input stream; x = {index, fraction}
//   out_valid, out_ready, y    output stream; y is signed
//   wr_en, wr_addr, wr_data    table write port
module pmvx_lut_interp
  import pmvx_lut_pkg::*;
#(
  parameter int unsigned IDX_W  = DefIdxW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned OW     = DefOw
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W+FRAC_W-1:0] x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OW-1:0]    y,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_addr,
  input  logic signed [OW-1:0]    wr_data
);

  localparam int unsigned IW = IDX_W + FRAC_W;
  localparam int unsigned PW = OW + FRAC_W + 1;

  logic                    en;
  logic [IDX_W-1:0]        idx;
  logic [FRAC_W-1:0]       frac;
  logic [IDX_W-1:0]        rd_addr_b;
  logic [OW-1:0]           rd_data_a;
  logic [OW-1:0]           rd_data_b;
  logic                    v1_q, v2_q, v3_q;
  logic signed [OW-1:0]    a1_q, a2_q, y_q, y_d;

  // Whole pipeline advances together; only a held output blocks it.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;
  assign idx      = x[IW-1:FRAC_W];
  assign frac     = x[FRAC_W-1:0];

  pmvx_lut_table #(
    .IDX_W (IDX_W),
    .OW    (OW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (idx),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

`ifdef PMVX_LUT_INTERP_EN
  logic signed [OW-1:0]  b1_q;
  logic [FRAC_W-1:0]     f1_q;
  logic signed [PW-1:0]  p2_q, p_d, p_rnd, p_sh;
  logic signed [OW:0]    diff;
  logic signed [FRAC_W:0] f_s;

  // Top entry has no right neighbour: clamp so b == a there.
  assign rd_addr_b = (&idx) ? idx : idx + 1'b1;

  always_comb begin
    diff  = (OW+1)'(b1_q) - (OW+1)'(a1_q);
    f_s   = $signed({1'b0, f1_q});
    // Operands widened first so the product is not truncated.
    p_d   = PW'(diff) * PW'(f_s);
    p_rnd = p2_q + PW'(round_const(FRAC_W));
    p_sh  = p_rnd >>> FRAC_W;
    // f < 2**FRAC_W keeps the rounded step within |b-a|, so no overflow.
    y_d   = a2_q + OW'(p_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      b1_q <= '0;
      f1_q <= '0;
      a2_q <= '0;
      p2_q <= '0;
      y_q  <= '0;
    end else if (en) begin
      a1_q <= rd_data_a;
      b1_q <= rd_data_b;
      f1_q <= frac;
      a2_q <= a1_q;
      p2_q <= p_d;
      y_q  <= y_d;
    end
  end
`else
  logic unused_sig;

  assign rd_addr_b  = '0;
  assign unused_sig = ^{frac, rd_data_b};
  assign y_d        = a2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
      y_q  <= '0;
    end else if (en) begin
      a1_q <= rd_data_a;
      a2_q <= a1_q;
      y_q  <= y_d;
    end
  end
`endif

  assign out_valid = v3_q;
  assign y         = y_q;

endmodule

// File: tb/tb_pmvx_lut_interp.sv
// tb_pmvx_lut_interp: scoreboard bench for pmvx_lut_interp. Expected results
// are computed from a reference table model at acceptance and compared in
// order when the DUT delivers them. Inputs change #1 after rising edges;
// handshakes and outputs are observed on falling edges.
module tb_pmvx_lut_interp;

  localparam int IDX_W  = 5;
  localparam int FRAC_W = 4;
  localparam int OW     = 15;
  localparam int IW     = IDX_W + FRAC_W;
  localparam int DEPTH  = 2 ** IDX_W;

`ifdef PMVX_LUT_INTERP_EN
  localparam int Exp032 = -2346;
`else
  localparam int Exp032 = -2335;
`endif

  typedef struct {
    int y;
    int stamp;
    bit lat;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [IW-1:0]        x;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] y;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_addr;
  logic signed [OW-1:0] wr_data;

  exp_t q[$];
  exp_t e_pop;
  int   tbl [DEPTH];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   last_y = 0;
  bit   lat_chk = 0;
  bit   send_done = 0;

  pmvx_lut_interp #(
    .IDX_W  (IDX_W),
    .FRAC_W (FRAC_W),
    .OW     (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model(input int i, input int f);
    int a, b, p;
    a = tbl[i];
    b = (i == DEPTH - 1) ? a : tbl[i + 1];
    p = (b - a) * f;
`ifdef PMVX_LUT_INTERP_EN
    return a + ((p + (1 << (FRAC_W - 1))) >>> FRAC_W);
`else
    return a + 0 * p;
`endif
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    for (int k = 0; k < DEPTH; k++) tbl[k] = 0;
  end

  // Scoreboard: pop on delivery, push on acceptance, then mirror table writes.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          check_val("spurious_out", out_valid, 0);
        end else begin
          e_pop = q.pop_front();
          check_val("y", y, e_pop.y);
          if (e_pop.lat) check_val("latency", cyc - e_pop.stamp, 3);
          last_y = y;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(int'(x[IW-1:FRAC_W]), int'(x[FRAC_W-1:0])), cyc, lat_chk});
      end
      if (wr_en) tbl[wr_addr] = int'(wr_data);
    end
  end

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(a);
    wr_data = OW'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic send(input int i, input int f);
    int n = 0;
    x        = IW'((i << FRAC_W) | f);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check_val("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_left", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    logic signed [OW-1:0] y_hold;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_y", y, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("rel_in_ready", in_ready, 1);
    check_val("rel_out_valid", out_valid, 0);

    wr(0, -2335);
    wr(1, -2358);
    wr(31, -4879);
    for (int a = 2; a < 31; a++) wr(a, int'($urandom_range(0, 16383)) - 8192);

    // Single samples with latency checks, including the top-entry clamp.
    lat_chk = 1'b1;
    send(0, 8);
    drain();
    check_val("req032", last_y, Exp032);
    send(31, 15);
    drain();
    check_val("req033", last_y, -4879);
    send(31, 0);
    send(31, 7);
    send(30, 15);
    send(0, 0);
    send(0, 15);
    drain();

    // Back-to-back random stream.
    for (int k = 0; k < 8; k++) send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
    drain();

    // Ten-sample stream with a five-cycle output stall mid-stream.
    lat_chk = 1'b0;
    cnt0 = out_cnt;
    fork
      begin
        for (int k = 0; k < 10; k++) send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        y_hold = y;
        check_val("stall_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          check_val("stall_in_ready", in_ready, 0);
          check_val("stall_y_held", y, y_hold);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_val("stream_count", out_cnt - cnt0, 10);

    // Write coinciding with acceptance must not affect that sample.
    wr_en = 1'b1; wr_addr = '0; wr_data = OW'(100);
    send(0, 0);
    wr_en = 1'b0;
    drain();
    check_val("req035_old", last_y, -2335);
    send(0, 0);
    drain();
    check_val("req035_new", last_y, 100);

    // Random backpressure.
    send_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 15; k++) send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
        send_done = 1'b1;
      end
      begin
        for (int k = 0; k < 400 && !send_done; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three samples in flight.
    send(4, 3);
    send(5, 9);
    send(6, 12);
    rst_n = 1'b0;
    #1;
    check_val("inrst_out_valid", out_valid, 0);
    check_val("inrst_y", y, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt0 = out_cnt;
    repeat (8) @(posedge clk);
    #1;
    check_val("postrst_out_valid", out_valid, 0);
    check_val("postrst_no_stale", out_cnt - cnt0, 0);
    send(0, 8);
    drain();
    check_val("postrst_t0", last_y, 0);
    send(31, 15);
    send(17, 5);
    drain();
    check_val("postrst_t17", last_y, 0);
    check_val("postrst_count", out_cnt - cnt0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
